// File: rtl/display_scheduler.sv
// Arbitrates the 2-digit display between inserted amount, price and change messages,
// and time-multiplexes the tens/units segment patterns onto one shared bus.
module display_scheduler #(
  parameter int SCAN_DIV    = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] current_amount,
  input  logic       price_req,
  input  logic [4:0] price_value,
  input  logic       change_req,
  input  logic [4:0] change_value,
  input  logic [6:0] seg_a,
  input  logic [6:0] seg_b,
  output logic [4:0] disp_amount,
  output logic [1:0] disp_src,
  output logic       busy,
  output logic [6:0] seg_out,
  output logic [1:0] digit_en
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_AMOUNT, S_PRICE, S_CHANGE} state_t;

  state_t        r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [SW-1:0] r_scan_cnt;
  logic          r_digit_sel;

  // Arbitration: change beats price beats hold expiry; price is dropped while change shows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_AMOUNT;
      r_hold_cnt  <= '0;
      disp_amount <= '0;
      disp_src    <= 2'd0;
      busy        <= 1'b0;
    end else if (change_req) begin
      r_state     <= S_CHANGE;
      r_hold_cnt  <= HW'(HOLD_CYCLES - 1);
      disp_amount <= change_value;
      disp_src    <= 2'd2;
      busy        <= 1'b1;
    end else if (price_req && r_state != S_CHANGE) begin
      r_state     <= S_PRICE;
      r_hold_cnt  <= HW'(HOLD_CYCLES - 1);
      disp_amount <= price_value;
      disp_src    <= 2'd1;
      busy        <= 1'b1;
    end else if (r_state == S_AMOUNT || r_hold_cnt == '0) begin
      r_state     <= S_AMOUNT;
      disp_amount <= current_amount;
      disp_src    <= 2'd0;
      busy        <= 1'b0;
    end else begin
      r_hold_cnt  <= r_hold_cnt - HW'(1);
    end
  end

  // Digit scan runs free of arbitration; each digit stays lit for SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_digit_sel <= 1'b0;
      seg_out     <= 7'b0;
      digit_en    <= 2'b00;
    end else begin
      if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
        r_scan_cnt  <= '0;
        r_digit_sel <= ~r_digit_sel;
      end else begin
        r_scan_cnt  <= r_scan_cnt + SW'(1);
      end
      seg_out  <= r_digit_sel ? seg_a : seg_b;
      digit_en <= r_digit_sel ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a cycle-level reference model and a
// stand-in display_controller that turns disp_amount into tens/units patterns.
module tb_display_scheduler;
  localparam int SCAN_DIV = 4;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] current_amount, price_value, change_value;
  logic       price_req, change_req;
  logic [6:0] seg_a, seg_b, seg_out;
  logic [4:0] disp_amount;
  logic [1:0] disp_src, digit_en;
  logic       busy;

  int errors = 0;
  int checks = 0;

  display_scheduler #(.SCAN_DIV(SCAN_DIV), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .current_amount(current_amount),
    .price_req(price_req), .price_value(price_value),
    .change_req(change_req), .change_value(change_value),
    .seg_a(seg_a), .seg_b(seg_b), .disp_amount(disp_amount),
    .disp_src(disp_src), .busy(busy), .seg_out(seg_out), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'h3F; 1: pat = 7'h06; 2: pat = 7'h5B; 3: pat = 7'h4F; 4: pat = 7'h66;
      5: pat = 7'h6D; 6: pat = 7'h7D; 7: pat = 7'h07; 8: pat = 7'h7F; 9: pat = 7'h6F;
      default: pat = 7'h00;
    endcase
  endfunction

  // Combinational stand-in for display_controller.
  always_comb begin
    seg_a = pat(int'(disp_amount) / 10);
    seg_b = pat(int'(disp_amount) % 10);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining message cycles and cycles since reset.
  int         m_amt, m_src, m_rem, m_k, m_en, m_seg;
  bit         started = 0;
  initial forever begin
    int prev;
    @(posedge clk);
    prev = m_amt;
    started = 1;
    if (!rst_n) begin
      m_amt = 0; m_src = 0; m_rem = 0; m_k = 0; m_en = 0; m_seg = 0;
    end else begin
      m_en  = ((m_k / SCAN_DIV) % 2 == 1) ? 2 : 1;
      m_seg = (m_en == 2) ? int'(pat(prev / 10)) : int'(pat(prev % 10));
      m_k++;
      if (change_req) begin
        m_src = 2; m_amt = int'(change_value); m_rem = HOLD;
      end else if (price_req && m_src != 2) begin
        m_src = 1; m_amt = int'(price_value); m_rem = HOLD;
      end else if (m_rem > 1) begin
        m_rem--;
      end else begin
        m_src = 0; m_amt = int'(current_amount); m_rem = 0;
      end
    end
  end

  // Compare process: every cycle after the first edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("m_disp_amount", int'(disp_amount), m_amt);
      chk("m_disp_src", int'(disp_src), m_src);
      chk("m_busy", int'(busy), (m_src != 0) ? 1 : 0);
      chk("m_digit_en", int'(digit_en), m_en);
      chk("m_seg_out", int'(seg_out), m_seg);
      checks++;
      if (digit_en == 2'b11) begin
        errors++;
        $display("FAIL digit_en_onehot: got 3 expected not 3 at %0t", $time);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; current_amount = 5'd0; price_req = 1'b0; price_value = 5'd0;
    change_req = 1'b0; change_value = 5'd0;
    cyc(2);
    chk("rst_amount", int'(disp_amount), 0);
    chk("rst_en", int'(digit_en), 0);
    chk("rst_seg", int'(seg_out), 0);
    chk("rst_busy", int'(busy), 0);

    rst_n = 1'b1; current_amount = 5'd9;
    cyc(1);
    chk("amt9", int'(disp_amount), 9);
    chk("first_en", int'(digit_en), 1);
    cyc(1);
    chk("units9", int'(seg_out), 'h6F);
    cyc(3);
    chk("tens_en", int'(digit_en), 2);
    chk("tens0", int'(seg_out), 'h3F);

    // Price message held exactly HOLD cycles.
    current_amount = 5'd5; cyc(1);
    price_req = 1'b1; price_value = 5'd15; cyc(1); price_req = 1'b0;
    chk("price_src", int'(disp_src), 1);
    chk("price_amt", int'(disp_amount), 15);
    chk("price_busy", int'(busy), 1);
    cyc(15);
    chk("price_last", int'(disp_src), 1);
    cyc(1);
    chk("price_end_src", int'(disp_src), 0);
    chk("price_end_amt", int'(disp_amount), 5);

    // Change preempts price on hold cycle 6.
    price_req = 1'b1; price_value = 5'd15; cyc(1); price_req = 1'b0;
    cyc(5);
    change_req = 1'b1; change_value = 5'd3; cyc(1); change_req = 1'b0;
    chk("pre_src", int'(disp_src), 2);
    chk("pre_amt", int'(disp_amount), 3);
    cyc(15);
    chk("pre_last", int'(busy), 1);
    cyc(1);
    chk("pre_end", int'(disp_src), 0);

    // Simultaneous requests: change wins, price never shown.
    price_req = 1'b1; price_value = 5'd20; change_req = 1'b1; change_value = 5'd7;
    cyc(1); price_req = 1'b0; change_req = 1'b0;
    chk("sim_src", int'(disp_src), 2);
    chk("sim_amt", int'(disp_amount), 7);
    cyc(16);
    chk("sim_end_amt", int'(disp_amount), 5);

    // Price ignored during change; second change restarts hold.
    change_req = 1'b1; change_value = 5'd10; cyc(1); change_req = 1'b0;
    cyc(3);
    price_req = 1'b1; price_value = 5'd23; cyc(1); price_req = 1'b0;
    chk("ign_amt", int'(disp_amount), 10);
    cyc(4);
    change_req = 1'b1; change_value = 5'd31; cyc(1); change_req = 1'b0;
    chk("re_amt", int'(disp_amount), 31);
    cyc(15);
    chk("re_last", int'(disp_src), 2);
    cyc(1);
    chk("re_end", int'(disp_src), 0);

    // Reset mid-hold.
    change_req = 1'b1; change_value = 5'd23; cyc(1); change_req = 1'b0;
    cyc(5);
    rst_n = 1'b0; cyc(1);
    chk("mrst_amt", int'(disp_amount), 0);
    chk("mrst_src", int'(disp_src), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_en", int'(digit_en), 0);
    rst_n = 1'b1; current_amount = 5'd12; cyc(1);
    chk("post_amt", int'(disp_amount), 12);
    chk("post_en", int'(digit_en), 1);
    cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
